spwm_sequencer: RTL and testbench

Run/stop and protection sequencer for the three-phase sine-PWM inverter datapath. It sits between the three sine-vs-carrier comparators and the bridge pins. It drives the amplitude that scales the sine generator outputs, precharges bootstrap supplies, and ramps amplitude up and down once per carrier period. It also inserts dead time into each complementary gate pair and forces a safe all-off state on fault.

---
 rtl/spwm_pkg.sv | 19 +
 rtl/deadtime_gen.sv | 55 +++++
 rtl/spwm_sequencer.sv | 139 +++++++++++++
 tb/tb_spwm_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared types and default constants for the sine-PWM run/stop sequencer.
package spwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_RAMP      = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMPDN    = 3'd4,
    ST_FAULT     = 3'd5
  } spwm_state_e;

  localparam int unsigned DT_CYCLES_DEF        = 12;
  localparam int unsigned PRECHARGE_CYCLES_DEF = 1200;
  localparam int unsigned AMP_W_DEF            = 12;
  localparam int unsigned AMP_STEP_DEF         = 4;
  localparam int unsigned AMP_MAX_DEF          = 2047;

endpackage

// File: rtl/deadtime_gen.sv
// One complementary gate pair: registered outputs with dead time inserted on
// every comparator change, plus forced low-side-on and all-off modes.
module deadtime_gen
  import spwm_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmp,
  input  logic force_lo,
  input  logic force_off,
  output logic gate_h,
  output logic gate_l
);

  localparam int CW = $clog2(DT_CYCLES + 1);

  // target is the last sampled comparator level; cnt counts down the dead
  // time still owed before the matching gate may turn on (0 = settled).
  logic          target;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= 1'b0;
      cnt    <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else if (force_off) begin
      target <= cmp;
      cnt    <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else if (force_lo) begin
      // Leaving precharge, a phase whose comparator is high sees a change.
      target <= 1'b0;
      cnt    <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b1;
    end else if (cmp != target) begin
      target <= cmp;
      cnt    <= CW'(DT_CYCLES);
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else if (cnt == CW'(1)) begin
      cnt    <= '0;
      gate_h <= target;
      gate_l <= ~target;
    end else if (cnt != '0) begin
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spwm_sequencer.sv
// Run/stop/fault sequencer for the three-phase sine-PWM bridge: owns the
// state machine, bootstrap precharge timer and amplitude ramp.
module spwm_sequencer
  import spwm_pkg::*;
#(
  parameter int unsigned DT_CYCLES        = DT_CYCLES_DEF,
  parameter int unsigned PRECHARGE_CYCLES = PRECHARGE_CYCLES_DEF,
  parameter int unsigned AMP_W            = AMP_W_DEF,
  parameter int unsigned AMP_STEP         = AMP_STEP_DEF,
  parameter int unsigned AMP_MAX          = AMP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             fault,
  input  logic             fault_clr,
  input  logic             carrier_pk,
  input  logic             cmp_a,
  input  logic             cmp_b,
  input  logic             cmp_c,
  output logic             gate_ah,
  output logic             gate_al,
  output logic             gate_bh,
  output logic             gate_bl,
  output logic             gate_ch,
  output logic             gate_cl,
  output logic [AMP_W-1:0] amp,
  output logic [2:0]       state
);

  localparam int PC_W = $clog2(PRECHARGE_CYCLES + 1);
  localparam logic [PC_W-1:0]  PRE_LAST = PC_W'(PRECHARGE_CYCLES - 1);
  localparam logic [AMP_W:0]   STEP_X   = (AMP_W + 1)'(AMP_STEP);
  localparam logic [AMP_W:0]   MAX_X    = (AMP_W + 1)'(AMP_MAX);
  localparam logic [AMP_W-1:0] STEP_N   = AMP_W'(AMP_STEP);
  localparam logic [AMP_W-1:0] MAX_N    = AMP_W'(AMP_MAX);

  spwm_state_e      state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [PC_W-1:0]  pre_q, pre_d;
  logic [AMP_W:0]   amp_up_x;
  logic [AMP_W-1:0] amp_up, amp_dn;
  logic             force_off, force_lo;

  // Saturating steps; the up sum is one bit wider so it cannot wrap.
  always_comb begin
    amp_up_x = {1'b0, amp_q} + STEP_X;
    amp_up   = (amp_up_x >= MAX_X) ? MAX_N : amp_up_x[AMP_W-1:0];
    amp_dn   = (amp_q > STEP_N) ? (amp_q - STEP_N) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      amp_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      pre_q   <= pre_d;
    end
  end

  // The ramp direction follows the state being entered, so a carrier peak
  // coinciding with a run_req change steps the new way.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    pre_d   = pre_q;
    if (fault) begin
      state_d = ST_FAULT;
      amp_d   = '0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          amp_d = '0;
          if (run_req) state_d = ST_PRECHARGE;
        end
        ST_PRECHARGE: begin
          if (!run_req) begin
            state_d = ST_IDLE;
            pre_d   = '0;
          end else if (pre_q == PRE_LAST) begin
            state_d = ST_RAMP;
            pre_d   = '0;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_RAMP, ST_RUN, ST_RAMPDN: begin
          if (run_req && state_q != ST_RUN) begin
            state_d = ST_RAMP;
            if (carrier_pk) begin
              amp_d = amp_up;
              if (amp_up == MAX_N) state_d = ST_RUN;
            end
          end else if (!run_req) begin
            state_d = ST_RAMPDN;
            if (carrier_pk) begin
              amp_d = amp_dn;
              if (amp_dn == '0) state_d = ST_IDLE;
            end
          end
        end
        ST_FAULT: begin
          amp_d = '0;
          if (fault_clr && !run_req) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_FAULT;
          amp_d   = '0;
          pre_d   = '0;
        end
      endcase
    end
    force_off = (state_d == ST_IDLE) || (state_d == ST_FAULT);
    force_lo  = (state_d == ST_PRECHARGE);
  end

  deadtime_gen #(.DT_CYCLES(DT_CYCLES)) u_dt_a (
    .clk(clk), .rst_n(rst_n), .cmp(cmp_a), .force_lo(force_lo),
    .force_off(force_off), .gate_h(gate_ah), .gate_l(gate_al)
  );

  deadtime_gen #(.DT_CYCLES(DT_CYCLES)) u_dt_b (
    .clk(clk), .rst_n(rst_n), .cmp(cmp_b), .force_lo(force_lo),
    .force_off(force_off), .gate_h(gate_bh), .gate_l(gate_bl)
  );

  deadtime_gen #(.DT_CYCLES(DT_CYCLES)) u_dt_c (
    .clk(clk), .rst_n(rst_n), .cmp(cmp_c), .force_lo(force_lo),
    .force_off(force_off), .gate_h(gate_ch), .gate_l(gate_cl)
  );

  assign amp   = amp_q;
  assign state = state_q;

endmodule

// File: tb/tb_spwm_sequencer.sv
// Self-checking bench for spwm_sequencer: startup table, directed corner
// sequences, then random stimulus against a behavioural model.
module tb_spwm_sequencer;

  localparam int DT = 3, PRE = 8, STEP = 512, MAX = 2047, AW = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic run_req = 1'b0, fault = 1'b0, fault_clr = 1'b0, carrier_pk = 1'b0;
  logic cmp_a = 1'b0, cmp_b = 1'b0, cmp_c = 1'b0;
  logic gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
  logic [AW-1:0] amp;
  logic [2:0]    state;

  int tests = 0, fails = 0;

  spwm_sequencer #(
    .DT_CYCLES(DT), .PRECHARGE_CYCLES(PRE), .AMP_W(AW),
    .AMP_STEP(STEP), .AMP_MAX(MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .fault(fault),
    .fault_clr(fault_clr), .carrier_pk(carrier_pk),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh),
    .gate_bl(gate_bl), .gate_ch(gate_ch), .gate_cl(gate_cl),
    .amp(amp), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string name, int st, int am, logic [2:0] gh, logic [2:0] gl);
    logic [2:0] ah, al;
    ah = {gate_ah, gate_bh, gate_ch};
    al = {gate_al, gate_bl, gate_cl};
    tests++;
    if (state !== 3'(st) || amp !== AW'(am) || ah !== gh || al !== gl) begin
      fails++;
      $display("FAIL %s: got state=%0d amp=%0d gh=%b gl=%b, expected state=%0d amp=%0d gh=%b gl=%b",
               name, state, amp, ah, al, st, am, gh, gl);
    end
    tests++;
    if ((ah & al) !== 3'b000) begin
      fails++;
      $display("FAIL %s overlap: gh=%b gl=%b, required no phase with both gates on", name, ah, al);
    end
  endtask

  task automatic go_run();
    run_req = 1'b1;
    repeat (PRE + 1) tick();
    carrier_pk = 1'b1;
    repeat (4) tick();
    carrier_pk = 1'b0;
  endtask

  // ---------------- startup vector table ----------------
  typedef struct {
    logic       run;
    logic       pk;
    logic [2:0] cmp;
    int         st;
    int         am;
    logic [2:0] gh;
    logic [2:0] gl;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic run, logic pk, logic [2:0] cmp, int st, int am,
                              logic [2:0] gh, logic [2:0] gl);
    vec_t v;
    v.run = run; v.pk = pk; v.cmp = cmp; v.st = st; v.am = am; v.gh = gh; v.gl = gl;
    return v;
  endfunction

  // ---------------- behavioural model (random phase) ----------------
  int m_state, m_amp, m_pre_elapsed;
  int lv[3][$];   // per-phase window of the last DT+1 levels seen (2 = forced off)

  task automatic model_reset();
    m_state = 0; m_amp = 0; m_pre_elapsed = 0;
    for (int p = 0; p < 3; p++) lv[p].delete();
  endtask

  task automatic model_edge();
    logic [2:0] cv;
    cv = {cmp_a, cmp_b, cmp_c};
    if (fault) begin
      m_state = 5; m_amp = 0;
    end else begin
      case (m_state)
        0: if (run_req) begin m_state = 1; m_pre_elapsed = 1; end
        1: begin
          if (!run_req) m_state = 0;
          else if (m_pre_elapsed == PRE) m_state = 2;
          else m_pre_elapsed++;
        end
        2, 3, 4: begin
          if (!run_req) begin
            m_state = 4;
            if (carrier_pk) begin
              m_amp = (m_amp - STEP < 0) ? 0 : m_amp - STEP;
              if (m_amp == 0) m_state = 0;
            end
          end else if (m_state != 3) begin
            m_state = 2;
            if (carrier_pk) begin
              m_amp = (m_amp + STEP > MAX) ? MAX : m_amp + STEP;
              if (m_amp == MAX) m_state = 3;
            end
          end
        end
        5: if (fault_clr && !run_req) m_state = 0;
        default: m_state = 5;
      endcase
    end
    for (int p = 0; p < 3; p++) begin
      int l;
      if (m_state == 1) l = 0;
      else if (m_state >= 2 && m_state <= 4) l = int'(cv[2-p]);
      else l = 2;
      lv[p].push_back(l);
      if (lv[p].size() > DT + 1) void'(lv[p].pop_front());
    end
  endtask

  task automatic model_gates(output logic [2:0] gh, output logic [2:0] gl);
    gh = 3'b000; gl = 3'b000;
    for (int p = 0; p < 3; p++) begin
      if (m_state == 1) begin
        gl[2-p] = 1'b1;
      end else if (m_state >= 2 && m_state <= 4 && lv[p].size() == DT + 1) begin
        bit same;
        same = 1'b1;
        foreach (lv[p][k]) if (lv[p][k] != lv[p][0]) same = 1'b0;
        if (same && lv[p][0] == 1) gh[2-p] = 1'b1;
        if (same && lv[p][0] == 0) gl[2-p] = 1'b1;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    logic [2:0] egh, egl;

    for (int i = 0; i < 8; i++) vecs[i] = mk(1'b1, 1'b0, 3'b010, 1, 0, 3'b000, 3'b111);
    vecs[8]  = mk(1'b1, 1'b0, 3'b010, 2, 0,    3'b000, 3'b101);
    vecs[9]  = mk(1'b1, 1'b1, 3'b010, 2, 512,  3'b000, 3'b101);
    vecs[10] = mk(1'b1, 1'b1, 3'b010, 2, 1024, 3'b000, 3'b101);
    vecs[11] = mk(1'b1, 1'b1, 3'b010, 2, 1536, 3'b010, 3'b101);
    vecs[12] = mk(1'b1, 1'b1, 3'b010, 3, 2047, 3'b010, 3'b101);

    // Reset
    @(negedge clk);
    check("reset_hold", 0, 0, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 0, 0, 3'b000, 3'b000);

    // Startup table: precharge, RAMP entry with phase b high, four peaks
    for (int i = 0; i < 13; i++) begin
      run_req    = vecs[i].run;
      carrier_pk = vecs[i].pk;
      {cmp_a, cmp_b, cmp_c} = vecs[i].cmp;
      tick();
      check($sformatf("startup[%0d]", i), vecs[i].st, vecs[i].am, vecs[i].gh, vecs[i].gl);
    end
    carrier_pk = 1'b0;

    // Dead time on phase a: rise, fall, then a one-cycle glitch
    cmp_a = 1'b1;
    tick(); check("dt_rise_n0", 3, MAX, 3'b010, 3'b001);
    for (int k = 1; k < DT; k++) begin
      tick(); check($sformatf("dt_rise_n%0d", k), 3, MAX, 3'b010, 3'b001);
    end
    tick(); check("dt_rise_on", 3, MAX, 3'b110, 3'b001);
    cmp_a = 1'b0;
    for (int k = 0; k < DT; k++) begin
      tick(); check($sformatf("dt_fall_n%0d", k), 3, MAX, 3'b010, 3'b001);
    end
    tick(); check("dt_fall_on", 3, MAX, 3'b010, 3'b101);
    cmp_a = 1'b1;
    tick(); check("glitch_g0", 3, MAX, 3'b010, 3'b001);
    cmp_a = 1'b0;
    for (int k = 1; k <= DT; k++) begin
      tick(); check($sformatf("glitch_g%0d", k), 3, MAX, 3'b010, 3'b001);
    end
    tick(); check("glitch_low_back", 3, MAX, 3'b010, 3'b101);

    // Stop and resume
    run_req = 1'b0;
    tick(); check("stop_enter", 4, 2047, 3'b010, 3'b101);
    carrier_pk = 1'b1;
    tick(); check("down_1535", 4, 1535, 3'b010, 3'b101);
    tick(); check("down_1023", 4, 1023, 3'b010, 3'b101);
    carrier_pk = 1'b0; run_req = 1'b1;
    tick(); check("resume_ramp", 2, 1023, 3'b010, 3'b101);
    carrier_pk = 1'b1;
    tick(); check("resume_1535", 2, 1535, 3'b010, 3'b101);
    tick(); check("resume_run", 3, 2047, 3'b010, 3'b101);
    run_req = 1'b0;
    tick(); check("stop_pk_same_edge", 4, 1535, 3'b010, 3'b101);
    tick(); check("stop_1023", 4, 1023, 3'b010, 3'b101);
    tick(); check("stop_511", 4, 511, 3'b010, 3'b101);
    tick(); check("stop_idle", 0, 0, 3'b000, 3'b000);
    carrier_pk = 1'b0;

    // Fault
    go_run();
    check("fault_pre_run", 3, 2047, 3'b010, 3'b101);
    fault = 1'b1; carrier_pk = 1'b1;
    tick(); check("fault_enter", 5, 0, 3'b000, 3'b000);
    fault = 1'b0; carrier_pk = 1'b0; fault_clr = 1'b1;
    tick(); check("fault_clr_run_hi", 5, 0, 3'b000, 3'b000);
    run_req = 1'b0; fault = 1'b1;
    tick(); check("fault_clr_fault_hi", 5, 0, 3'b000, 3'b000);
    fault = 1'b0;
    tick(); check("fault_exit", 0, 0, 3'b000, 3'b000);
    fault_clr = 1'b0;

    // Asynchronous reset mid-RUN
    go_run();
    check("reset_pre_run", 3, 2047, 3'b010, 3'b101);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 0, 0, 3'b000, 3'b000);
    run_req = 1'b0; {cmp_a, cmp_b, cmp_c} = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) run_req = ~run_req;
      fault      = ($urandom_range(0, 149) == 0);
      fault_clr  = ($urandom_range(0, 7) == 0);
      carrier_pk = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) cmp_a = ~cmp_a;
      if ($urandom_range(0, 5) == 0) cmp_b = ~cmp_b;
      if ($urandom_range(0, 5) == 0) cmp_c = ~cmp_c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_gates(egh, egl);
      check($sformatf("rand[%0d]", n), m_state, m_amp, egh, egl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
